// File: rtl/mem_access.sv
// RV32I memory-access stage: runs loads/stores as single-beat AXI4 transfers
// and forwards non-memory results straight to writeback.
module mem_access #(
   parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
   parameter int C_M_AXI_ADDR_WIDTH      = 32,
   parameter int C_M_AXI_DATA_WIDTH      = 32
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic                               I_VALID,
   input  logic [6:0]                         I_OPCODE,
   input  logic [2:0]                         I_FUNCT3,
   input  logic [31:0]                        I_ADDR,
   input  logic [31:0]                        I_WDATA,
   input  logic [4:0]                         I_REG_D,
   output logic                               MEM_WAIT,
   output logic                               O_VALID,
   output logic                               O_WB_EN,
   output logic [4:0]                         O_REG_D,
   output logic [31:0]                        O_DATA,
   output logic                               O_EXC,
   output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
   output logic [7:0]                         M_AXI_AWLEN,
   output logic [2:0]                         M_AXI_AWSIZE,
   output logic [1:0]                         M_AXI_AWBURST,
   output logic                               M_AXI_AWLOCK,
   output logic [3:0]                         M_AXI_AWCACHE,
   output logic [2:0]                         M_AXI_AWPROT,
   output logic [3:0]                         M_AXI_AWQOS,
   output logic                               M_AXI_AWUSER,
   output logic                               M_AXI_AWVALID,
   input  logic                               M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
   output logic                               M_AXI_WLAST,
   output logic                               M_AXI_WUSER,
   output logic                               M_AXI_WVALID,
   input  logic                               M_AXI_WREADY,
   input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_BID,
   input  logic [1:0]                         M_AXI_BRESP,
   input  logic                               M_AXI_BUSER,
   input  logic                               M_AXI_BVALID,
   output logic                               M_AXI_BREADY,
   output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
   output logic [7:0]                         M_AXI_ARLEN,
   output logic [2:0]                         M_AXI_ARSIZE,
   output logic [1:0]                         M_AXI_ARBURST,
   output logic                               M_AXI_ARLOCK,
   output logic [3:0]                         M_AXI_ARCACHE,
   output logic [2:0]                         M_AXI_ARPROT,
   output logic [3:0]                         M_AXI_ARQOS,
   output logic                               M_AXI_ARUSER,
   output logic                               M_AXI_ARVALID,
   input  logic                               M_AXI_ARREADY,
   input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
   input  logic [1:0]                         M_AXI_RRESP,
   input  logic                               M_AXI_RLAST,
   input  logic                               M_AXI_RUSER,
   input  logic                               M_AXI_RVALID,
   output logic                               M_AXI_RREADY
);

   // state   | meaning
   // S_IDLE  | ready for a new op; passthrough and misaligned ops finish here
   // S_RD_A  | ARVALID held until ARREADY
   // S_RD_D  | RREADY high, waiting for the read beat
   // S_WR_AW | AWVALID/WVALID each held until their own READY
   // S_WR_B  | BREADY high, waiting for the write response
   typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_D, S_WR_AW, S_WR_B} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_addr, r_wdata;
   logic [3:0]  r_wstrb;
   logic [2:0]  r_funct3;
   logic [4:0]  r_reg_d;
   logic        r_aw_done, r_w_done;
   logic        r_o_valid, r_o_wb_en, r_o_exc;
   logic [4:0]  r_o_reg_d;
   logic [31:0] r_o_data;

   logic        w_is_ld, w_is_st, w_is_ldst, w_misal, w_accept;
   logic        w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready, w_mem_wait;
   logic [31:0] w_wdata_rep, w_rshift, w_ld_data;
   logic [3:0]  w_wstrb;
   logic        w_unused;

   assign w_is_ld   = (I_OPCODE == 7'b0000011);
   assign w_is_st   = (I_OPCODE == 7'b0100011);
   assign w_is_ldst = w_is_ld | w_is_st;
   assign w_misal   = ((I_FUNCT3[1:0] == 2'b01) & I_ADDR[0]) |
                      (I_FUNCT3[1] & (I_ADDR[1:0] != 2'b00));
   assign w_accept  = (r_state == S_IDLE) & I_VALID;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && !w_misal) begin
                     if (w_is_ld)      w_state_nxt = S_RD_A;
                     else if (w_is_st) w_state_nxt = S_WR_AW;
                  end
         S_RD_A:  if (M_AXI_ARREADY) w_state_nxt = S_RD_D;
         S_RD_D:  if (M_AXI_RVALID)  w_state_nxt = S_IDLE;
         S_WR_AW: if ((r_aw_done | M_AXI_AWREADY) && (r_w_done | M_AXI_WREADY))
                     w_state_nxt = S_WR_B;
         S_WR_B:  if (M_AXI_BVALID)  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_arvalid  = (r_state == S_RD_A);
      w_rready   = (r_state == S_RD_D);
      w_awvalid  = (r_state == S_WR_AW) & ~r_aw_done;
      w_wvalid   = (r_state == S_WR_AW) & ~r_w_done;
      w_bready   = (r_state == S_WR_B);
      w_mem_wait = (r_state != S_IDLE) | (I_VALID & w_is_ldst);
   end

   always_comb begin
      w_wdata_rep = I_WDATA;
      w_wstrb     = 4'hF;
      case (I_FUNCT3[1:0])
         2'b00: begin
            w_wdata_rep = {4{I_WDATA[7:0]}};
            w_wstrb     = 4'b0001 << I_ADDR[1:0];
         end
         2'b01: begin
            w_wdata_rep = {2{I_WDATA[15:0]}};
            w_wstrb     = 4'b0011 << I_ADDR[1:0];
         end
         default: ;
      endcase
   end

   assign w_rshift = M_AXI_RDATA >> {r_addr[1:0], 3'b000};

   always_comb begin
      w_ld_data = M_AXI_RDATA;
      case (r_funct3)
         3'b000: w_ld_data = {{24{w_rshift[7]}}, w_rshift[7:0]};
         3'b001: w_ld_data = {{16{w_rshift[15]}}, w_rshift[15:0]};
         3'b100: w_ld_data = {24'h0, w_rshift[7:0]};
         3'b101: w_ld_data = {16'h0, w_rshift[15:0]};
         default: ;
      endcase
   end

   // Lane replication and strobes are resolved at accept so the W channel is a plain register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_funct3  <= '0;
         r_reg_d   <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else if (w_accept) begin
         r_addr    <= I_ADDR;
         r_wdata   <= w_wdata_rep;
         r_wstrb   <= w_wstrb;
         r_funct3  <= I_FUNCT3;
         r_reg_d   <= I_REG_D;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         if (w_awvalid && M_AXI_AWREADY) r_aw_done <= 1'b1;
         if (w_wvalid && M_AXI_WREADY)   r_w_done  <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_o_valid <= 1'b0;
         r_o_wb_en <= 1'b0;
         r_o_exc   <= 1'b0;
         r_o_reg_d <= '0;
         r_o_data  <= '0;
      end else begin
         r_o_valid <= 1'b0;
         r_o_wb_en <= 1'b0;
         r_o_exc   <= 1'b0;
         if (w_accept && !w_is_ldst) begin
            r_o_valid <= 1'b1;
            r_o_wb_en <= (I_REG_D != 5'd0);
            r_o_reg_d <= I_REG_D;
            r_o_data  <= I_ADDR;
         end else if (w_accept && w_misal) begin
            r_o_valid <= 1'b1;
            r_o_exc   <= 1'b1;
            r_o_reg_d <= I_REG_D;
         end else if (w_rready && M_AXI_RVALID) begin
            r_o_valid <= 1'b1;
            r_o_exc   <= (M_AXI_RRESP != 2'b00);
            r_o_wb_en <= (M_AXI_RRESP == 2'b00) && (r_reg_d != 5'd0);
            r_o_reg_d <= r_reg_d;
            r_o_data  <= w_ld_data;
         end else if (w_bready && M_AXI_BVALID) begin
            r_o_valid <= 1'b1;
            r_o_exc   <= (M_AXI_BRESP != 2'b00);
            r_o_reg_d <= r_reg_d;
         end
      end
   end

   assign MEM_WAIT      = w_mem_wait;
   assign O_VALID       = r_o_valid;
   assign O_WB_EN       = r_o_wb_en;
   assign O_REG_D       = r_o_reg_d;
   assign O_DATA        = r_o_data;
   assign O_EXC         = r_o_exc;

   assign M_AXI_AWID    = '0;
   assign M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'({r_addr[31:2], 2'b00});
   assign M_AXI_AWLEN   = 8'd0;
   assign M_AXI_AWSIZE  = 3'b010;
   assign M_AXI_AWBURST = 2'b01;
   assign M_AXI_AWLOCK  = 1'b0;
   assign M_AXI_AWCACHE = 4'b0011;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWQOS   = 4'b0000;
   assign M_AXI_AWUSER  = 1'b0;
   assign M_AXI_AWVALID = w_awvalid;
   assign M_AXI_WDATA   = C_M_AXI_DATA_WIDTH'(r_wdata);
   assign M_AXI_WSTRB   = (C_M_AXI_DATA_WIDTH/8)'(r_wstrb);
   assign M_AXI_WLAST   = 1'b1;
   assign M_AXI_WUSER   = 1'b0;
   assign M_AXI_WVALID  = w_wvalid;
   assign M_AXI_BREADY  = w_bready;
   assign M_AXI_ARID    = '0;
   assign M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'({r_addr[31:2], 2'b00});
   assign M_AXI_ARLEN   = 8'd0;
   assign M_AXI_ARSIZE  = 3'b010;
   assign M_AXI_ARBURST = 2'b01;
   assign M_AXI_ARLOCK  = 1'b0;
   assign M_AXI_ARCACHE = 4'b0011;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARQOS   = 4'b0000;
   assign M_AXI_ARUSER  = 1'b0;
   assign M_AXI_ARVALID = w_arvalid;
   assign M_AXI_RREADY  = w_rready;

   assign w_unused = ^{M_AXI_BID, M_AXI_BUSER, M_AXI_RID, M_AXI_RLAST, M_AXI_RUSER};

endmodule
